// File: rtl/neural_result_sequencer.sv
// neural_result_sequencer
// Collects one frame of class scores from the network as a serial stream,
// keeps a running arg-max of the scores above threshold, and presents the
// winning digit (or "no class" / "frame error") to the display path through
// a valid/ack handshake. New scores are held off while a result is pending.

module neural_result_sequencer #(
   parameter int                NUM_CLASSES = 10,
   parameter int                DATA_W      = 16,
   parameter logic [DATA_W-1:0] THRESH      = 16'h0400
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              clear,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   input  logic              in_last,
   output logic              in_ready,
   output logic              result_valid,
   output logic [3:0]        result_digit,
   output logic [DATA_W-1:0] result_max,
   output logic              frame_err,
   input  logic              result_ack,
   output logic              busy
);

   // Result codes shared with the seven-segment decoder.
   localparam logic [3:0] DIGIT_NONE  = 4'hA;
   localparam logic [3:0] DIGIT_ERROR = 4'hF;

   // Index of the final score of a well-formed frame.
   localparam logic [3:0] LAST_IDX = 4'(NUM_CLASSES - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state_reg, state_next;

   // Running frame accumulators: beat index, best qualifying class so far.
   logic [3:0]        count_reg, count_next;
   logic [3:0]        best_idx_reg, best_idx_next;
   logic [DATA_W-1:0] best_val_reg, best_val_next;

   // Published result; persists on the display until the next frame ends.
   logic [3:0]        digit_reg, digit_next;
   logic [DATA_W-1:0] max_reg, max_next;
   logic              err_reg, err_next;

   // Per-beat decode.
   logic              beat_ok;
   logic              at_last_idx;
   logic              frame_end;
   logic              normal_end;
   logic              qualifies;
   logic [3:0]        cand_idx;
   logic [DATA_W-1:0] cand_val;

   // Handshake outputs derive directly from the state so the display sees a
   // clean registered result_valid and the network a simple stall condition.
   assign in_ready     = (state_reg != DONE) & ~clear;
   assign result_valid = (state_reg == DONE);
   assign busy         = (state_reg != IDLE);
   assign result_digit = digit_reg;
   assign result_max   = max_reg;
   assign frame_err    = err_reg;

   // Beat acceptance, frame-end classification and the running arg-max step.
   always_comb begin
      beat_ok     = in_valid & in_ready;
      at_last_idx = (count_reg == LAST_IDX);
      // Either in_last or running out of classes closes the frame; a frame
      // is well formed only when both coincide.
      frame_end   = beat_ok & (in_last | at_last_idx);
      normal_end  = in_last & at_last_idx;
      // Strict compares: scores equal to the threshold do not qualify, and
      // a later equal score never displaces an earlier one.
      qualifies   = (in_data > THRESH) && (in_data > best_val_reg);
      cand_idx    = qualifies ? count_reg : best_idx_reg;
      cand_val    = qualifies ? in_data   : best_val_reg;
   end

   // Next-state logic; clear has priority over every other event.
   always_comb begin
      state_next = state_reg;
      if (clear) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (beat_ok) begin
                  state_next = frame_end ? DONE : ACCUM;
               end
            end
            ACCUM: begin
               if (frame_end) begin
                  state_next = DONE;
               end
            end
            DONE: begin
               if (result_ack) begin
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Accumulator update: advance on each accepted beat, restart after the
   // frame closes so the next frame begins from class 0 with no candidate.
   always_comb begin
      count_next    = count_reg;
      best_idx_next = best_idx_reg;
      best_val_next = best_val_reg;
      if (clear) begin
         count_next    = '0;
         best_idx_next = DIGIT_NONE;
         best_val_next = '0;
      end else if (beat_ok) begin
         if (frame_end) begin
            count_next    = '0;
            best_idx_next = DIGIT_NONE;
            best_val_next = '0;
         end else begin
            count_next    = count_reg + 4'd1;
            best_idx_next = cand_idx;
            best_val_next = cand_val;
         end
      end
   end

   // Result capture at frame end; the closing beat's own score is included
   // through the candidate path. Clear never touches the displayed result.
   always_comb begin
      digit_next = digit_reg;
      max_next   = max_reg;
      err_next   = err_reg;
      if (!clear && frame_end) begin
         if (normal_end) begin
            // cand_idx is still DIGIT_NONE when nothing qualified, and
            // cand_val is then zero.
            digit_next = cand_idx;
            max_next   = cand_val;
            err_next   = 1'b0;
         end else begin
            digit_next = DIGIT_ERROR;
            max_next   = '0;
            err_next   = 1'b1;
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Frame accumulator registers; a reset discards any partial frame.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count_reg    <= '0;
         best_idx_reg <= DIGIT_NONE;
         best_val_reg <= '0;
      end else begin
         count_reg    <= count_next;
         best_idx_reg <= best_idx_next;
         best_val_reg <= best_val_next;
      end
   end

   // Published result registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         digit_reg <= DIGIT_NONE;
         max_reg   <= '0;
         err_reg   <= 1'b0;
      end else begin
         digit_reg <= digit_next;
         max_reg   <= max_next;
         err_reg   <= err_next;
      end
   end

endmodule

// File: tb/tb_neural_result_sequencer.sv
// tb_neural_result_sequencer
// Directed frames against a frame-level model (score queue + arg-max),
// checked every cycle, plus hand-computed expectations per frame.

module tb_neural_result_sequencer;

   localparam int          N  = 10;
   localparam logic [15:0] TH = 16'h0400;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        clear = 1'b0;
   logic [15:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic        in_ready;
   logic        result_valid;
   logic [3:0]  result_digit;
   logic [15:0] result_max;
   logic        frame_err;
   logic        result_ack = 1'b0;
   logic        busy;

   int n_vec = 0;
   int n_mis = 0;

   neural_result_sequencer #(
      .NUM_CLASSES(N),
      .DATA_W(16),
      .THRESH(TH)
   ) dut (
      .clk(clk),
      .n_rst(n_rst),
      .clear(clear),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_last(in_last),
      .in_ready(in_ready),
      .result_valid(result_valid),
      .result_digit(result_digit),
      .result_max(result_max),
      .frame_err(frame_err),
      .result_ack(result_ack),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- frame-level model ----------------
   bit          m_pending = 1'b0;
   logic [15:0] m_q[$];
   logic [3:0]  m_digit = 4'hA;
   logic [15:0] m_max = '0;
   logic        m_err = 1'b0;

   task automatic model_reset();
      m_pending = 1'b0;
      m_q.delete();
      m_digit = 4'hA;
      m_max = '0;
      m_err = 1'b0;
   endtask

   task automatic model_close(input bit last);
      int best;
      int bv;
      best = -1;
      bv = 0;
      if (last && m_q.size() == N) begin
         foreach (m_q[i]) begin
            if (m_q[i] > TH && int'(m_q[i]) > bv) begin
               best = i;
               bv = int'(m_q[i]);
            end
         end
         m_digit = (best < 0) ? 4'hA : 4'(best);
         m_max = 16'(bv);
         m_err = 1'b0;
      end else begin
         m_digit = 4'hF;
         m_max = '0;
         m_err = 1'b1;
      end
      m_pending = 1'b1;
      m_q.delete();
   endtask

   initial begin
      forever begin
         @(posedge clk or negedge n_rst);
         if (!n_rst) begin
            model_reset();
         end else if (clear) begin
            m_pending = 1'b0;
            m_q.delete();
         end else if (m_pending) begin
            if (result_ack) m_pending = 1'b0;
         end else if (in_valid) begin
            m_q.push_back(in_data);
            if (in_last || m_q.size() == N) model_close(in_last);
         end
      end
   end

   // Cycle-by-cycle comparison against the model.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         chk("in_ready",     in_ready,     !m_pending && !clear);
         chk("result_valid", result_valid, m_pending);
         chk("busy",         busy,         m_pending || m_q.size() > 0);
         chk("result_digit", result_digit, m_digit);
         chk("result_max",   result_max,   m_max);
         chk("frame_err",    frame_err,    m_err);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic beat(input logic [15:0] d, input bit l);
      int t;
      t = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data = d;
      in_last = l;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) chk("beat_accept_timeout", in_ready, 1);
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      in_last = 1'b0;
      in_data = '0;
   endtask

   task automatic send(input logic [15:0] s [N], input int n, input int last_at);
      for (int i = 0; i < n; i++) beat(s[i], (i == last_at));
   endtask

   task automatic wait_result(input string name, input logic [3:0] d, input logic [15:0] m, input logic e);
      int t;
      t = 0;
      while (!result_valid && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk({name, "_valid"}, result_valid, 1);
      chk({name, "_digit"}, result_digit, d);
      chk({name, "_max"},   result_max,   m);
      chk({name, "_err"},   frame_err,    e);
      $display("frame %s: digit=%0h max=%04h err=%0b", name, result_digit, result_max, frame_err);
   endtask

   task automatic do_ack();
      @(negedge clk);
      result_ack = 1'b1;
      @(negedge clk);
      result_ack = 1'b0;
      chk("ack_ready", in_ready, 1);
      chk("ack_valid", result_valid, 0);
   endtask

   task automatic reset_check(input string name);
      chk({name, "_ready"}, in_ready, 1);
      chk({name, "_valid"}, result_valid, 0);
      chk({name, "_digit"}, result_digit, 4'hA);
      chk({name, "_max"},   result_max, 0);
      chk({name, "_err"},   frame_err, 0);
      chk({name, "_busy"},  busy, 0);
   endtask

   logic [15:0] f_main [N] = '{16'h0100, 16'h0300, 16'h0800, 16'h0500, 16'h0100,
                               16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0200};
   logic [15:0] f_thr  [N] = '{default: 16'h0400};
   logic [15:0] f_tie  [N] = '{16'h0000, 16'h0000, 16'h0000, 16'h0900, 16'h0000,
                               16'h0000, 16'h0000, 16'h0900, 16'h0000, 16'h0000};
   logic [15:0] f_ramp [N] = '{16'h0100, 16'h0500, 16'h0600, 16'h0700, 16'h0800,
                               16'h0900, 16'h0A00, 16'h0B00, 16'h0C00, 16'h0D00};
   logic [15:0] f_rest [N] = '{16'h0F00, 16'h0100, 16'h0100, 16'h0100, 16'h0100,
                               16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clk);
      reset_check("reset");
      n_rst = 1'b1;
      @(negedge clk);
      reset_check("post_reset");

      // Normal frame: best at index 2.
      send(f_main, N, N - 1);
      idle();
      wait_result("main", 4'h2, 16'h0800, 1'b0);
      do_ack();

      // Scores equal to threshold never qualify.
      send(f_thr, N, N - 1);
      idle();
      wait_result("at_thresh", 4'hA, 16'h0000, 1'b0);
      do_ack();

      // Tie resolves to the lower index.
      send(f_tie, N, N - 1);
      idle();
      wait_result("tie", 4'h3, 16'h0900, 1'b0);
      do_ack();

      // Early in_last on beat 5.
      send(f_ramp, 6, 5);
      idle();
      wait_result("early_last", 4'hF, 16'h0000, 1'b1);
      do_ack();

      // Ten beats without in_last, then an 11th beat held off while pending.
      send(f_ramp, N, -1);
      @(negedge clk);
      in_valid = 1'b1;
      in_data = 16'h0F00;
      in_last = 1'b0;
      wait_result("no_last", 4'hF, 16'h0000, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("stall_ready", in_ready, 0);
         chk("stall_digit", result_digit, 4'hF);
      end
      result_ack = 1'b1;
      @(negedge clk);
      result_ack = 1'b0;
      chk("stall_release_ready", in_ready, 1);
      @(posedge clk);
      for (int i = 1; i < N; i++) beat(f_rest[i], (i == N - 1));
      idle();
      wait_result("after_stall", 4'h0, 16'h0F00, 1'b0);
      do_ack();

      // Clear mid-frame: offered beat refused, previous result retained.
      send(f_ramp, 4, -1);
      @(negedge clk);
      in_valid = 1'b1;
      in_data = 16'h0F00;
      clear = 1'b1;
      #1;
      chk("clear_ready", in_ready, 0);
      @(negedge clk);
      clear = 1'b0;
      in_valid = 1'b0;
      chk("clear_busy", busy, 0);
      chk("clear_digit", result_digit, 4'h0);
      send(f_main, N, N - 1);
      idle();
      wait_result("after_clear", 4'h2, 16'h0800, 1'b0);
      do_ack();

      // Asynchronous reset mid-frame.
      send(f_ramp, 6, -1);
      @(negedge clk);
      n_rst = 1'b0;
      in_valid = 1'b0;
      #1;
      reset_check("rst_midframe");
      @(negedge clk);
      n_rst = 1'b1;
      send(f_tie, N, N - 1);
      idle();
      wait_result("after_rst1", 4'h3, 16'h0900, 1'b0);

      // Asynchronous reset while a result is pending.
      @(negedge clk);
      n_rst = 1'b0;
      #1;
      reset_check("rst_done");
      @(negedge clk);
      n_rst = 1'b1;
      send(f_main, N, N - 1);
      idle();
      wait_result("after_rst2", 4'h2, 16'h0800, 1'b0);
      do_ack();

      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
